// File: rtl/config_loader_uc.sv
// Control unit that drives the serial receiver and loads N_WORDS configuration words into the bank.
// It requests a resend on parity errors and aborts when the retry limit or the per-word timeout is reached.
module config_loader_uc #(
  parameter int unsigned N_WORDS        = 4,
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT_CICLOS = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              rx_pronto,
  input  logic              rx_erro,
  input  logic [15:0]       rx_dado,
  output logic              receber_config,
  output logic              cfg_we,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic [15:0]       cfg_data,
  output logic              nack,
  output logic              ocupado,
  output logic              pronto,
  output logic              erro,
  output logic [2:0]        db_estado
);

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned TIMER_W = 32;
  localparam logic [ADDR_W-1:0]  LAST_IDX    = ADDR_W'(N_WORDS - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CICLOS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ESPERA  = 3'd1,
    ESCREVE = 3'd2,
    REPETE  = 3'd3,
    FIM     = 3'd4,
    ERRO    = 3'd5
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0]  idx;
  logic [RETRY_W-1:0] retries;
  logic [TIMER_W-1:0] timer;
  logic [RETRY_W-1:0] retries_inc;

  assign retries_inc = retries + RETRY_W'(1);
  assign cfg_addr    = idx;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (iniciar) next_state = ESPERA;
      ESPERA: begin
        if (rx_erro)                  next_state = REPETE;
        else if (rx_pronto)           next_state = ESCREVE;
        else if (timer == TIMER_LAST) next_state = ERRO;
      end
      ESCREVE: next_state = (idx == LAST_IDX) ? FIM : ESPERA;
      REPETE:  next_state = (retries_inc == RETRY_LIMIT) ? ERRO : ESPERA;
      FIM:     next_state = iniciar ? ESPERA : IDLE;
      ERRO:    if (iniciar) next_state = ESPERA;
      default: next_state = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    receber_config = 1'b0;
    cfg_we         = 1'b0;
    nack           = 1'b0;
    ocupado        = 1'b0;
    pronto         = 1'b0;
    erro           = 1'b0;
    db_estado      = state;
    case (state)
      ESPERA:  begin receber_config = 1'b1; ocupado = 1'b1; end
      ESCREVE: begin cfg_we = 1'b1; ocupado = 1'b1; end
      REPETE:  begin nack = 1'b1; ocupado = 1'b1; end
      FIM:     pronto = 1'b1;
      ERRO:    erro = 1'b1;
      default: ;
    endcase
  end

  // Word index, retry count, timeout counter and latched word
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx      <= '0;
      retries  <= '0;
      timer    <= '0;
      cfg_data <= '0;
    end else begin
      case (state)
        IDLE, FIM, ERRO: begin
          if (iniciar) begin
            idx     <= '0;
            retries <= '0;
            timer   <= '0;
          end
        end
        ESPERA: begin
          timer <= timer + TIMER_W'(1);
          if (!rx_erro && rx_pronto) cfg_data <= rx_dado;
        end
        ESCREVE: begin
          if (idx != LAST_IDX) begin
            idx     <= idx + ADDR_W'(1);
            retries <= '0;
            timer   <= '0;
          end
        end
        REPETE: begin
          retries <= retries_inc;
          timer   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader_uc.sv
// Directed bench for config_loader_uc: load, parity retry, retry abort, timeout and event overlap.
module tb_config_loader_uc;

  logic        clock = 1'b0;
  logic        reset, iniciar, rx_pronto, rx_erro;
  logic [15:0] rx_dado;
  logic        receber_config, cfg_we, nack, ocupado, pronto, erro;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [2:0]  db_estado;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int nack_cnt = 0;
  int pr_cnt   = 0;

  config_loader_uc #(
    .N_WORDS(4), .ADDR_W(2), .MAX_RETRIES(3), .TIMEOUT_CICLOS(10)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .rx_pronto(rx_pronto),
    .rx_erro(rx_erro), .rx_dado(rx_dado), .receber_config(receber_config),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .nack(nack),
    .ocupado(ocupado), .pronto(pronto), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (cfg_we) we_cnt++;
    if (nack)   nack_cnt++;
    if (pronto) pr_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {receber_config, cfg_we, nack, ocupado, pronto, erro}
  function automatic logic [31:0] flags();
    return {26'd0, receber_config, cfg_we, nack, ocupado, pronto, erro};
  endfunction

  // Deliver one word after 'waits' idle ESPERA cycles and check the write strobe
  task automatic send_word(input logic [1:0] idx, input logic [15:0] w, input int waits);
    for (int k = 0; k < waits; k++) tick();
    rx_pronto = 1'b1; rx_dado = w;
    tick();
    rx_pronto = 1'b0;
    chk($sformatf("write_state_%0d", idx), 32'(db_estado), 32'd2);
    chk($sformatf("write_flags_%0d", idx), flags(), 32'b010100);
    chk($sformatf("write_addr_%0d", idx), 32'(cfg_addr), 32'(idx));
    chk($sformatf("write_data_%0d", idx), 32'(cfg_data), 32'(w));
    tick();
  endtask

  task automatic parity_err(input string tag);
    rx_erro = 1'b1;
    tick();
    rx_erro = 1'b0;
    chk({tag, "_state"}, 32'(db_estado), 32'd3);
    chk({tag, "_flags"}, flags(), 32'b001100);
    tick();
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b1; rx_pronto = 1'b1; rx_erro = 1'b0; rx_dado = 16'hAAAA;
    tick(); tick();
    chk("reset_state", 32'(db_estado), 32'd0);
    chk("reset_flags", flags(), 32'd0);
    chk("reset_addr", 32'(cfg_addr), 32'd0);
    chk("reset_data", 32'(cfg_data), 32'd0);
    chk("reset_we_cnt", 32'(we_cnt), 32'd0);
    reset = 1'b1; iniciar = 1'b0; rx_pronto = 1'b0;
    tick();
    chk("idle_state", 32'(db_estado), 32'd0);

    // Normal load, each word three cycles into ESPERA
    we_cnt = 0; pr_cnt = 0;
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    chk("start_state", 32'(db_estado), 32'd1);
    chk("start_flags", flags(), 32'b100100);
    send_word(2'd0, 16'h1234, 2);
    send_word(2'd1, 16'hABCD, 2);
    send_word(2'd2, 16'h0001, 2);
    send_word(2'd3, 16'hFFFF, 2);
    chk("fim_state", 32'(db_estado), 32'd4);
    chk("fim_flags", flags(), 32'b000010);
    tick();
    chk("back_idle", 32'(db_estado), 32'd0);
    chk("load_we_cnt", 32'(we_cnt), 32'd4);
    chk("load_pronto_cnt", 32'(pr_cnt), 32'd1);
    chk("idle_addr_hold", 32'(cfg_addr), 32'd3);

    // Parity retry on word 1
    we_cnt = 0; nack_cnt = 0; pr_cnt = 0;
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    send_word(2'd0, 16'h0101, 0);
    parity_err("retry1");
    chk("retry_addr", 32'(cfg_addr), 32'd1);
    parity_err("retry2");
    chk("retry_back_espera", 32'(db_estado), 32'd1);
    send_word(2'd1, 16'h5555, 0);
    send_word(2'd2, 16'h0202, 1);
    send_word(2'd3, 16'h0303, 0);
    chk("retry_fim", 32'(db_estado), 32'd4);
    tick();
    chk("retry_nack_cnt", 32'(nack_cnt), 32'd2);
    chk("retry_we_cnt", 32'(we_cnt), 32'd4);
    chk("retry_pronto_cnt", 32'(pr_cnt), 32'd1);

    // Retry abort on word 0
    we_cnt = 0; nack_cnt = 0;
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    parity_err("abort1");
    parity_err("abort2");
    rx_erro = 1'b1; tick(); rx_erro = 1'b0;
    chk("abort3_state", 32'(db_estado), 32'd3);
    tick();
    chk("abort_state", 32'(db_estado), 32'd5);
    chk("abort_flags", flags(), 32'b000001);
    rx_pronto = 1'b1; tick(); tick(); rx_pronto = 1'b0;
    chk("abort_hold", 32'(db_estado), 32'd5);
    chk("abort_nack_cnt", 32'(nack_cnt), 32'd3);
    chk("abort_we_cnt", 32'(we_cnt), 32'd0);
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    chk("restart_state", 32'(db_estado), 32'd1);
    chk("restart_addr", 32'(cfg_addr), 32'd0);

    // Timeout: ERRO on the tenth edge in ESPERA
    for (int k = 0; k < 9; k++) tick();
    chk("timeout_pre", 32'(db_estado), 32'd1);
    tick();
    chk("timeout_state", 32'(db_estado), 32'd5);
    chk("timeout_flags", flags(), 32'b000001);

    // rx_pronto on the timeout cycle is accepted
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    send_word(2'd0, 16'hBEEF, 0);
    chk("late_word_no_erro", 32'(db_estado), 32'd1);
    chk("late_word_addr", 32'(cfg_addr), 32'd1);

    // rx_pronto and rx_erro together: resend, no write
    we_cnt = 0;
    rx_pronto = 1'b1; rx_erro = 1'b1; rx_dado = 16'h7777;
    tick();
    rx_pronto = 1'b0; rx_erro = 1'b0;
    chk("both_state", 32'(db_estado), 32'd3);
    chk("both_flags", flags(), 32'b001100);
    chk("both_data", 32'(cfg_data), 32'hBEEF);
    tick();
    chk("both_we_cnt", 32'(we_cnt), 32'd0);

    // iniciar ignored in ESPERA
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    chk("ign_start_state", 32'(db_estado), 32'd1);
    chk("ign_start_addr", 32'(cfg_addr), 32'd1);

    // Reset mid-block
    reset = 1'b0; tick(); reset = 1'b1;
    chk("midreset_state", 32'(db_estado), 32'd0);
    chk("midreset_addr", 32'(cfg_addr), 32'd0);
    chk("midreset_flags", flags(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_loader_uc.md
Name: config_loader_uc

Overview:
Control unit that sequences the 16-bit serial receiver to load a block of N_WORDS configuration words into the config register bank. It enables the receiver, waits for each word, and writes each good word to consecutive addresses. It requests a resend on parity errors and aborts on a retry limit or a per-word timeout. It sits between the system start logic and the receiver/config-bank datapath.

Parameters:
N_WORDS, 4, number of 16-bit words per configuration block (1..2^ADDR_W)
ADDR_W, 2, width of cfg_addr
MAX_RETRIES, 3, resend requests allowed per word before abort (1..15)
TIMEOUT_CICLOS, 50000000, clock cycles allowed per word before abort (>=2, fits 32 bits)

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
iniciar  in  1  start pulse; honoured only in IDLE, FIM or ERRO
rx_pronto  in  1  one-cycle pulse from receiver: 16-bit word valid on rx_dado
rx_erro  in  1  one-cycle pulse from receiver: parity error on current word
rx_dado  in  16  received word, valid when rx_pronto=1
receber_config  out  1  receiver enable; 1 only in ESPERA
cfg_we  out  1  config bank write strobe (one cycle)
cfg_addr  out  ADDR_W  write address = current word index
cfg_data  out  16  latched word
nack  out  1  one-cycle resend request to sender
ocupado  out  1  1 in ESPERA, ESCREVE, REPETE
pronto  out  1  one-cycle pulse: block loaded
erro  out  1  level: load aborted; held in ERRO
db_estado  out  3  current state code

Behaviour:
- States/codes: IDLE=0, ESPERA=1, ESCREVE=2, REPETE=3, FIM=4, ERRO=5. Outputs are decoded from the registered state (Moore), except cfg_addr/cfg_data, which come from registers.
- Reset (reset=0 at an edge): state IDLE; word index, retry count and timeout counter 0; cfg_data 0. All outputs 0, db_estado=0. Reset wins over every other input in any state.
- IDLE: if iniciar=1, go to ESPERA with index=0, retries=0, timer=0.
- ESPERA: timer increments each cycle. Priority, highest first:
  - rx_erro=1: go to REPETE.
  - rx_pronto=1: latch rx_dado into cfg_data; go to ESCREVE.
  - timer==TIMEOUT_CICLOS-1: go to ERRO.
  - otherwise stay in ESPERA.
- rx_pronto in the same cycle as the timeout is accepted.
- ESCREVE (1 cycle): cfg_we=1, cfg_addr=index, cfg_data=latched word.
  - If index==N_WORDS-1, go to FIM.
  - Otherwise index+1, retries=0, timer=0, go to ESPERA.
- REPETE (1 cycle): nack=1; retries+1.
  - If the new retries==MAX_RETRIES, go to ERRO.
  - Otherwise timer=0 and go to ESPERA. The index is unchanged.
- FIM (1 cycle): pronto=1.
  - If iniciar=1, restart as from IDLE.
  - Otherwise go to IDLE.
- ERRO: erro=1, held indefinitely. iniciar=1 restarts as from IDLE (index, retries, timer cleared). No other exit except reset.
- iniciar is ignored in ESPERA, ESCREVE and REPETE. rx_pronto and rx_erro are ignored outside ESPERA.
- Latency: rx_pronto at edge k gives cfg_we=1 during cycle k+1. After the last word's write, pronto=1 the next cycle.
- Total minimum cycles from iniciar to pronto: 1 + N_WORDS*2 + 1, with rx_pronto arriving the first cycle of each ESPERA.
- cfg_addr holds the index in all states; it changes only on leaving ESCREVE or on restart.

Test Plan:
- Reset: hold reset=0 for 2 cycles with iniciar=1 and rx_pronto=1 → all outputs 0, db_estado=0, no cfg_we.
- Normal load with N_WORDS=4: iniciar, then words 0x1234, 0xABCD, 0x0001, 0xFFFF, each pulsed 3 cycles after entering ESPERA → cfg_we at addresses 0,1,2,3 with the matching data, exactly 4 strobes. Then one pronto pulse and return to db_estado=0.
- Parity retry with MAX_RETRIES=3: word 1 gets rx_erro twice, then rx_pronto with 0x5555 → two nack pulses; cfg_addr stays 1; write of 0x5555 at address 1; load completes with pronto.
- Retry abort: word 0 gets rx_erro 3 times → 3 nack pulses, then erro=1 held, db_estado=5, no cfg_we. Then iniciar → restart at index 0.
- Timeout with TIMEOUT_CICLOS=10: no rx_pronto → ERRO reached 10 cycles after entering ESPERA. Separately, rx_pronto exactly on cycle 10 → word accepted, no erro.
- Simultaneous events:
  - rx_pronto and rx_erro in the same cycle → REPETE, nack=1, no write.
  - iniciar during ESPERA → ignored.
  - reset=0 mid-block → IDLE next edge and index=0.
